// File: rtl/digit_scanner.sv
// Four-digit multiplexed 7-segment scanner with frame shadows and adjust blink.
// Optional LEADING_ZERO_BLANK_EN blanks a zero minute-tens digit.
module digit_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] minute1,
  input  logic [3:0] minute2,
  input  logic [3:0] second1,
  input  logic [3:0] second2,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  logic [RW-1:0]   rcnt;
  logic [BW-1:0]   bcnt;
  logic [1:0]      idx;
  logic            phase;
  logic [3:0][3:0] sh;

  logic       tick;
  logic       btick;
  logic [3:0] digit;
  logic       blank;
  logic [6:0] glyph;

  assign tick  = (rcnt == RW'(REFRESH_DIV - 1));
  assign btick = (bcnt == BW'(BLINK_DIV - 1));

  always_comb begin
    digit = sh[idx];
    // sel=1 targets the seconds pair, which lives at idx 0 and 1
    blank = adj & phase & (sel == ~idx[1]);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 2'd3 && digit == 4'd0)
      blank = 1'b1;
`endif
    case (digit)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b0111111;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt  <= '0;
      bcnt  <= '0;
      idx   <= 2'd0;
      phase <= 1'b0;
      sh    <= '0;
      an    <= 4'b1111;
      seg   <= 7'b1111111;
      dp    <= 1'b1;
    end else begin
      rcnt <= tick ? '0 : rcnt + 1'b1;
      bcnt <= btick ? '0 : bcnt + 1'b1;
      if (btick)
        phase <= ~phase;
      if (tick) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3)
          sh <= {minute1, minute2, second1, second2};
      end
      an  <= blank ? 4'b1111 : ~(4'b0001 << idx);
      seg <= blank ? 7'b1111111 : glyph;
      dp  <= ~((idx == 2'd2) & ~blank);
    end
  end

endmodule

// File: tb/tb_digit_scanner.sv
// Randomized scoreboard bench for digit_scanner.
// Expected outputs derive from elapsed cycle count and frame snapshots.
module tb_digit_scanner;

  localparam int R = 4;
  localparam int B = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] minute1, minute2, second1, second2;
  logic       adj, sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int failures = 0;

  logic [11:0] q[$];
  logic [3:0]  shm[4];
  logic [6:0]  lut[10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                           7'b0110000, 7'b0011001, 7'b0010010,
                           7'b0000010, 7'b1111000, 7'b0000000,
                           7'b0010000};

  digit_scanner #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst),
    .minute1(minute1), .minute2(minute2),
    .second1(second1), .second2(second2),
    .adj(adj), .sel(sel),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  // n = clock edges completed since reset release before the edge being predicted
  function automatic logic [11:0] model(int n, logic a, logic s);
    int i;
    int ph;
    logic [3:0] d;
    bit bl;
    logic [3:0] an_e;
    logic [6:0] sg_e;
    logic dp_e;
    i = (n / R) % 4;
    ph = (n / B) % 2;
    d = shm[i];
    bl = (a == 1'b1) && (ph == 1) &&
         ((s == 1'b1) ? (i < 2) : (i >= 2));
`ifdef LEADING_ZERO_BLANK_EN
    if (i == 3 && d == 4'd0) bl = 1'b1;
`endif
    an_e = 4'b1111;
    an_e[i] = bl ? 1'b1 : 1'b0;
    sg_e = bl ? 7'b1111111 : (d > 4'd9 ? 7'b0111111 : lut[d]);
    dp_e = (i == 2 && !bl) ? 1'b0 : 1'b1;
    return {an_e, sg_e, dp_e};
  endfunction

  function automatic logic [3:0] rnd_digit();
    if ($urandom_range(3) == 0) return 4'($urandom_range(15));
    return 4'($urandom_range(9));
  endfunction

  initial begin : monitor
    logic [11:0] e;
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL queue_empty t=%0t got an=%b seg=%b dp=%b",
                 $time, an, seg, dp);
      end else begin
        e = q.pop_front();
        if ({an, seg, dp} !== e) begin
          failures++;
          $display("FAIL out t=%0t got an=%b seg=%b dp=%b exp an=%b seg=%b dp=%b",
                   $time, an, seg, dp, e[11:8], e[7:1], e[0]);
        end
      end
    end
  end

  initial begin : driver
    int k;
    int cyc;
    int rst_hold;
    bit want_rst;
    rst = 1'b1;
    minute1 = 4'd1; minute2 = 4'd2;
    second1 = 4'd3; second2 = 4'd4;
    adj = 1'b0; sel = 1'b0;
    for (int i = 0; i < 4; i++) shm[i] = 4'd0;
    k = 0;
    rst_hold = 3;
    want_rst = 0;
    q.push_back({4'b1111, 7'b1111111, 1'b1});
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) begin
          rst = 1'b0;
          k = 0;
          for (int i = 0; i < 4; i++) shm[i] = 4'd0;
        end
      end
      if (cyc == 900 || cyc == 2100) want_rst = 1;
      if (rst_hold == 0 && want_rst && ((k / R) % 4) == 2 && (k % R) == 1) begin
        want_rst = 0;
        rst = 1'b1;
        rst_hold = 3;
        #1;
        checks++;
        if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
          failures++;
          $display("FAIL async_rst got an=%b seg=%b dp=%b exp an=1111 seg=1111111 dp=1",
                   an, seg, dp);
        end
      end
      if (cyc > 40 && rst_hold == 0) begin
        if ($urandom_range(7) == 0) begin
          case ($urandom_range(3))
            0: minute1 = ($urandom_range(2) == 0) ? 4'd0 : rnd_digit();
            1: minute2 = rnd_digit();
            2: second1 = rnd_digit();
            default: second2 = rnd_digit();
          endcase
        end
        if ($urandom_range(31) == 0) adj = ~adj;
        if ($urandom_range(31) == 0) sel = ~sel;
      end
      if (rst_hold > 0) begin
        q.push_back({4'b1111, 7'b1111111, 1'b1});
      end else begin
        k++;
        q.push_back(model(k - 1, adj, sel));
        if (k % (4 * R) == 0) begin
          shm[3] = minute1; shm[2] = minute2;
          shm[1] = second1; shm[0] = second2;
        end
      end
    end
    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
